// File: rtl/pipe_pkg.sv
// Shared definitions for the delay-line family: default data width and
// the helper that sizes the tap-select and occupancy fields.
package pipe_pkg;

    localparam int DEFAULT_SIZE = 32;

    // Bits needed to hold the value n itself, i.e. $clog2(n+1).
    function automatic int clog2_plus1(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((n >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One stage of the delay line: a valid bit plus a data word with
// reset > flush > stall > load priority.
module delay_stage #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            vin,
    input  logic [SIZE-1:0] din,
    output logic            vout,
    output logic [SIZE-1:0] dout
);

    logic            r_valid;
    logic [SIZE-1:0] r_data;

    // Bubbles load zero data so the line never carries stale or unknown words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (!stall) begin
            r_valid <= vin;
            r_data  <= vin ? din : '0;
        end
    end

    assign vout = r_valid;
    assign dout = r_data;

endmodule

// File: rtl/pipe_delay_line.sv
// Stallable, flushable DEPTH-stage delay line with a runtime-selectable
// output tap, per-stage tap outputs and a registered occupancy count.
module pipe_delay_line
    import pipe_pkg::*;
#(
    parameter int  SIZE  = DEFAULT_SIZE,
    parameter int  DEPTH = 4,
    localparam int SELW  = clog2_plus1(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [SIZE-1:0]       in_data,
    input  logic [SELW-1:0]       delay_sel,
    output logic                  out_valid,
    output logic [SIZE-1:0]       out_data,
    output logic [DEPTH-1:0]      taps_valid,
    output logic [SIZE*DEPTH-1:0] taps_data,
    output logic [SELW-1:0]       occ
);

    // Index 0 is the line input, index i is the output of stage i.
    logic [DEPTH:0]           w_vChain;
    logic [DEPTH:0][SIZE-1:0] w_dChain;
    logic [SELW-1:0]          w_tapSel;
    logic [SELW-1:0]          r_occ;

    assign w_vChain[0] = in_valid;
    assign w_dChain[0] = in_data;

    genvar i;
    generate
        for (i = 1; i <= DEPTH; i++) begin : g_stage
            delay_stage #(
                .SIZE (SIZE)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .stall (stall),
                .flush (flush),
                .vin   (w_vChain[i-1]),
                .din   (w_dChain[i-1]),
                .vout  (w_vChain[i]),
                .dout  (w_dChain[i])
            );
            assign taps_valid[i-1]             = w_vChain[i];
            assign taps_data[i*SIZE-1 -: SIZE] = w_dChain[i];
        end
    endgenerate

    // Occupancy tracks what enters stage 1 and what falls off the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (!stall) begin
            r_occ <= r_occ + SELW'(in_valid) - SELW'(w_vChain[DEPTH]);
        end
    end

    assign occ = r_occ;

    // Out-of-range selects (0 or above DEPTH) fall back to the last stage.
    always_comb begin
        w_tapSel = SELW'(DEPTH);
        if ((delay_sel != '0) && (int'(delay_sel) <= DEPTH)) begin
            w_tapSel = delay_sel;
        end
    end

    assign out_valid = w_vChain[w_tapSel];
    assign out_data  = w_dChain[w_tapSel];

endmodule
